// File: rtl/axis_in_dispatch_if.sv
// axis_in_dispatch_if: upstream AXI-Stream and shared-data one-hot downstream bundle
interface axis_in_dispatch_if #(
   parameter int DATA_W = 64,
   parameter int NUM_CH = 3
);
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic              s_axis_tlast;
   logic [DATA_W-1:0] m_tdata;
   logic [NUM_CH-1:0] m_tvalid;
   logic [NUM_CH-1:0] m_tready;
   logic              m_tlast;
   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_tready,
      input  s_axis_tready, m_tdata, m_tvalid, m_tlast
   );
   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_tready,
      output s_axis_tready, m_tdata, m_tvalid, m_tlast
   );
endinterface

// File: rtl/axis_in_dispatch.sv
// axis_in_dispatch: arms per frame, routes one stream through a 2-entry skid to NUM_CH channels, pulses bank swap after drain
module axis_in_dispatch #(
   parameter int DATA_W = 64,
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 16,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_arm,
   input  logic              i_abort,
   input  logic [SEL_W-1:0]  cfg_sel,
   input  logic [CNT_W-1:0]  cfg_frame_beats,
   axis_in_dispatch_if.slave bus,
   output logic [NUM_CH-1:0] o_swap_pulse,
   output logic              o_busy,
   output logic [CNT_W-1:0]  o_beat_cnt,
   output logic              o_err_len
);
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, SWAP} state_t;
   state_t            state, nxt;
   logic [SEL_W-1:0]  sel_q;
   logic [CNT_W-1:0]  beats_q;
   logic [DATA_W-1:0] mem [2];
   logic [1:0]        last_m;
   logic              wr_ptr, rd_ptr;
   logic [1:0]        occ;
   logic              acc, pop, arm_ok, flush, len_hit, push_last, len_err;
   logic [CNT_W-1:0]  cnt_nxt;
   // ready depends only on registered state, never on m_tready
   assign bus.s_axis_tready = state == STREAM && occ != 2'd2;
   assign acc       = bus.s_axis_tvalid && bus.s_axis_tready;
   assign pop       = occ != 2'd0 && bus.m_tready[sel_q];
   assign cnt_nxt   = o_beat_cnt + CNT_W'(1);
   assign len_hit   = beats_q != '0 && cnt_nxt == beats_q;
   assign push_last = bus.s_axis_tlast || len_hit;
   assign len_err   = bus.s_axis_tlast ? beats_q != '0 && !len_hit : len_hit;
   assign arm_ok    = state == IDLE && i_arm;
   assign flush     = state != IDLE && i_abort;
   assign bus.m_tvalid = occ != 2'd0 ? NUM_CH'(1) << sel_q : '0;
   assign bus.m_tdata  = mem[rd_ptr];
   assign bus.m_tlast  = occ != 2'd0 && last_m[rd_ptr];
   assign o_swap_pulse = state == SWAP ? NUM_CH'(1) << sel_q : '0;
   assign o_busy       = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = i_arm ? STREAM : IDLE;
         STREAM:  nxt = acc && push_last ? DRAIN : STREAM;
         DRAIN:   nxt = occ == 2'd0 ? SWAP : DRAIN;
         default: nxt = IDLE;
      endcase
      if (flush) nxt = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q      <= '0;
         beats_q    <= '0;
         o_beat_cnt <= '0;
         o_err_len  <= 1'b0;
         mem[0]     <= '0;
         mem[1]     <= '0;
         last_m     <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         occ        <= 2'd0;
      end else begin
         if (arm_ok) begin
            sel_q      <= {1'b0, cfg_sel} < (SEL_W+1)'(NUM_CH) ? cfg_sel : '0;
            beats_q    <= cfg_frame_beats;
            o_beat_cnt <= '0;
            o_err_len  <= 1'b0;
         end
         if (acc) begin
            mem[wr_ptr]    <= bus.s_axis_tdata;
            last_m[wr_ptr] <= push_last;
            o_beat_cnt     <= cnt_nxt;
            if (len_err) o_err_len <= 1'b1;
         end
         if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
         end else begin
            wr_ptr <= wr_ptr ^ acc;
            rd_ptr <= rd_ptr ^ pop;
            occ    <= occ + 2'(acc) - 2'(pop);
         end
      end
   end
endmodule

// File: tb/tb_axis_in_dispatch.sv
// tb_axis_in_dispatch: table frames, hand-timed corner cases and random frames against a frame-level model
module tb_axis_in_dispatch;
   localparam int DW = 64, NC = 3, CW = 16, SW = 2;
   logic          clk = 1'b0, rst = 1'b1, i_arm = 1'b0, i_abort = 1'b0;
   logic [SW-1:0] cfg_sel = '0;
   logic [CW-1:0] cfg_frame_beats = '0;
   logic [NC-1:0] o_swap_pulse;
   logic          o_busy;
   logic [CW-1:0] o_beat_cnt;
   logic          o_err_len;
   logic          rdy_rand = 1'b0;
   logic [NC-1:0] rdy_force = '1, rdy_rnd = '0;
   int            errors = 0, checks = 0, ob = 0, sb = 0;
   logic [DW-1:0] out_d [$];
   logic          out_l [$];
   logic [NC-1:0] out_v [$];
   logic [NC-1:0] sw_q [$];
   typedef struct {int sel; int fb; int n; int last_at; int ch; int cnt; bit err;} vec_t;
   vec_t tbl [6];

   axis_in_dispatch_if #(.DATA_W(DW), .NUM_CH(NC)) bus();
   axis_in_dispatch #(.DATA_W(DW), .NUM_CH(NC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .i_arm(i_arm), .i_abort(i_abort), .cfg_sel(cfg_sel),
      .cfg_frame_beats(cfg_frame_beats), .bus(bus), .o_swap_pulse(o_swap_pulse),
      .o_busy(o_busy), .o_beat_cnt(o_beat_cnt), .o_err_len(o_err_len)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rdy_rnd <= NC'($urandom);
   assign bus.m_tready = rdy_rand ? rdy_rnd : rdy_force;

   // log every downstream transfer and swap pulse mid-cycle
   always @(negedge clk) begin
      if ((bus.m_tvalid & bus.m_tready) != '0) begin
         out_d.push_back(bus.m_tdata);
         out_l.push_back(bus.m_tlast);
         out_v.push_back(bus.m_tvalid);
      end
      if (o_swap_pulse != '0) sw_q.push_back(o_swap_pulse);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic mark;
      ob = out_d.size();
      sb = sw_q.size();
   endtask

   task automatic arm(input int sel, input int fb);
      cfg_sel = SW'(sel);
      cfg_frame_beats = CW'(fb);
      i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
   endtask

   task automatic push_beats(input int first, input int last, input int last_at, input logic [63:0] base, input bit gaps);
      for (int k = first; k <= last; k++) begin
         int t;
         t = 0;
         if (gaps && $urandom_range(0, 2) == 0) begin
            bus.s_axis_tvalid = 1'b0;
            tick;
         end
         bus.s_axis_tdata  = base + 64'(k);
         bus.s_axis_tlast  = k == last_at;
         bus.s_axis_tvalid = 1'b1;
         while (!bus.s_axis_tready && t < 1000) begin
            tick;
            t++;
         end
         if (!bus.s_axis_tready) begin
            chk("accept_timeout", 64'(bus.s_axis_tready), 64'(1));
            bus.s_axis_tvalid = 1'b0;
            return;
         end
         tick;
      end
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_idle;
      int t;
      t = 0;
      while (o_busy && t < 2000) begin
         tick;
         t++;
      end
      if (o_busy) chk("idle_timeout", 64'(o_busy), 64'(0));
      tick;
      tick;
   endtask

   task automatic check_frame(input string tag, input int ch, input int k, input bit err, input logic [63:0] base);
      chk({tag, "_beats"}, 64'(out_d.size() - ob), 64'(k));
      for (int i = 0; i < k && ob + i < out_d.size(); i++) begin
         chk({tag, "_data"}, out_d[ob+i], base + 64'(i + 1));
         chk({tag, "_last"}, 64'(out_l[ob+i]), 64'(i == k - 1));
         chk({tag, "_valid"}, 64'(out_v[ob+i]), 64'(NC'(1) << ch));
      end
      chk({tag, "_swaps"}, 64'(sw_q.size() - sb), 64'(1));
      if (sw_q.size() > sb) chk({tag, "_swap_ch"}, 64'(sw_q[sb]), 64'(NC'(1) << ch));
      chk({tag, "_cnt"}, 64'(o_beat_cnt), 64'(k));
      chk({tag, "_err"}, 64'(o_err_len), 64'(err));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_tready"}, 64'(bus.s_axis_tready), 64'(0));
      chk({tag, "_tvalid"}, 64'(bus.m_tvalid), 64'(0));
      chk({tag, "_tdata"}, bus.m_tdata, 64'(0));
      chk({tag, "_tlast"}, 64'(bus.m_tlast), 64'(0));
      chk({tag, "_swap"}, 64'(o_swap_pulse), 64'(0));
      chk({tag, "_busy"}, 64'(o_busy), 64'(0));
      chk({tag, "_cnt"}, 64'(o_beat_cnt), 64'(0));
      chk({tag, "_err"}, 64'(o_err_len), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc, sel, fb, last_at, k, ch;
      bit err;
      logic [63:0] base;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      tick;
      tick;
      check_zero("reset");
      rst = 1'b0;
      tick;

      // table frames: {sel, frame_beats, beats sent, tlast beat, channel, count, err}
      tbl = '{'{1, 4, 4, 4, 1, 4, 1'b0},
              '{0, 6, 3, 3, 0, 3, 1'b1},
              '{2, 2, 2, 0, 2, 2, 1'b1},
              '{3, 3, 3, 3, 0, 3, 1'b0},
              '{1, 0, 300, 300, 1, 300, 1'b0},
              '{2, 5, 5, 5, 2, 5, 1'b0}};
      rdy_force = '1;
      for (int i = 0; i < 6; i++) begin
         base = 64'(i + 1) << 32;
         mark;
         arm(tbl[i].sel, tbl[i].fb);
         chk("arm_clr_err", 64'(o_err_len), 64'(0));
         chk("arm_clr_cnt", 64'(o_beat_cnt), 64'(0));
         push_beats(1, tbl[i].n, tbl[i].last_at, base, 1'b0);
         wait_idle;
         check_frame("tbl", tbl[i].ch, tbl[i].cnt, tbl[i].err, base);
      end

      // nominal cycle timing
      mark;
      arm(1, 4);
      for (int j = 1; j <= 4; j++) begin
         bus.s_axis_tdata  = 64'h11 * 64'(j);
         bus.s_axis_tlast  = j == 4;
         bus.s_axis_tvalid = 1'b1;
         chk("nom_tready", 64'(bus.s_axis_tready), 64'(1));
         tick;
         chk("nom_tvalid", 64'(bus.m_tvalid), 64'(3'b010));
         chk("nom_tdata", bus.m_tdata, 64'h11 * 64'(j));
         chk("nom_tlast", 64'(bus.m_tlast), 64'(j == 4));
      end
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      chk("nom_drain_tready", 64'(bus.s_axis_tready), 64'(0));
      tick;
      chk("nom_empty", 64'(bus.m_tvalid), 64'(0));
      chk("nom_swap_early", 64'(o_swap_pulse), 64'(0));
      tick;
      chk("nom_swap", 64'(o_swap_pulse), 64'(3'b010));
      tick;
      chk("nom_swap_once", 64'(o_swap_pulse), 64'(0));
      chk("nom_busy", 64'(o_busy), 64'(0));
      chk("nom_cnt", 64'(o_beat_cnt), 64'(4));
      chk("nom_err", 64'(o_err_len), 64'(0));

      // backpressure: downstream stalled five cycles
      mark;
      rdy_force = '0;
      arm(0, 8);
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         bus.s_axis_tdata  = 64'(acc + 1);
         bus.s_axis_tlast  = 1'b0;
         bus.s_axis_tvalid = 1'b1;
         if (bus.s_axis_tready) acc++;
         tick;
      end
      chk("bp_accepts", 64'(acc), 64'(2));
      chk("bp_tready", 64'(bus.s_axis_tready), 64'(0));
      chk("bp_hold_valid", 64'(bus.m_tvalid), 64'(3'b001));
      rdy_force = '1;
      push_beats(acc + 1, 8, 8, 64'(0), 1'b0);
      wait_idle;
      check_frame("bp", 0, 8, 1'b0, 64'(0));

      // abort with a beat still buffered, then re-arm to channel 2
      mark;
      arm(1, 5);
      push_beats(1, 2, 0, 64'h500, 1'b0);
      chk("abort_pre_valid", 64'(bus.m_tvalid), 64'(3'b010));
      i_abort = 1'b1;
      tick;
      i_abort = 1'b0;
      chk("abort_tvalid", 64'(bus.m_tvalid), 64'(0));
      chk("abort_busy", 64'(o_busy), 64'(0));
      chk("abort_cnt_hold", 64'(o_beat_cnt), 64'(2));
      repeat (4) tick;
      chk("abort_no_swap", 64'(sw_q.size() - sb), 64'(0));
      mark;
      arm(2, 3);
      push_beats(1, 3, 3, 64'h600, 1'b0);
      wait_idle;
      check_frame("rearm", 2, 3, 1'b0, 64'h600);

      // reset in the middle of a stalled frame
      mark;
      rdy_force = '0;
      arm(0, 8);
      push_beats(1, 2, 0, 64'h700, 1'b0);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check_zero("midrst");
      rdy_force = '1;
      repeat (3) tick;
      chk("midrst_no_swap", 64'(sw_q.size() - sb), 64'(0));

      // arm while draining must not retarget the frame
      mark;
      rdy_force = '0;
      arm(2, 2);
      push_beats(1, 2, 2, 64'h800, 1'b0);
      chk("drain_busy", 64'(o_busy), 64'(1));
      cfg_sel = 2'd0;
      cfg_frame_beats = CW'(7);
      i_arm = 1'b1;
      tick;
      i_arm = 1'b0;
      chk("drain_arm_valid", 64'(bus.m_tvalid), 64'(3'b100));
      rdy_force = '1;
      wait_idle;
      check_frame("drain_arm", 2, 2, 1'b0, 64'h800);

      // random frames: frame ends at the first of tlast or the length; error iff a length is set and tlast is not on it
      rdy_rand = 1'b1;
      for (int f = 0; f < 25; f++) begin
         sel = $urandom_range(0, 3);
         fb = $urandom_range(0, 6);
         last_at = $urandom_range(0, 8);
         if (fb == 0 && last_at == 0) last_at = $urandom_range(1, 8);
         k = (fb != 0 && (last_at == 0 || last_at > fb)) ? fb : last_at;
         err = fb != 0 && last_at != fb;
         ch = sel < NC ? sel : 0;
         base = 64'(f + 100) << 32;
         mark;
         arm(sel, fb);
         push_beats(1, k, last_at, base, 1'b1);
         wait_idle;
         check_frame("rnd", ch, k, err, base);
      end
      rdy_rand = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
